adcfifo_frame_ctrl: RTL
=======================

Name: adcfifo_frame_ctrl

Overview:
- Read-side sequencer for the 16-bit, 64-deep synchronous ADC sample FIFO.
- Waits until a full frame of samples is buffered, then drains exactly FRAME_LEN words and emits them as a framed stream (header, samples, checksum) on a valid/ready interface toward the packetizer/radio link.
- Tracks FIFO overflow/underflow as sticky errors and counts completed frames.

Parameters:
- FRAME_LEN, 32, samples per frame; range 1..64; must not exceed FIFO depth.
- RD_LAT, 1, cycles from FIFO_RE high to FIFO_Q valid; range 1..2.
- HDR_TAG, 8'hA5, upper byte of the header word.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  permits new frames to start; sampled only in IDLE.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_RDCNT  in  7  FIFO occupancy.
- FIFO_Q  in  16  FIFO read data.
- FIFO_OVERFLOW  in  1  FIFO overflow pulse.
- FIFO_UNDERFLOW  in  1  FIFO underflow pulse.
- FIFO_RE  out  1  FIFO read enable, active-high, one word per cycle.
- OUT_DATA  out  16  stream word.
- OUT_VALID  out  1  stream word valid.
- OUT_READY  in  1  downstream accept.
- OUT_SOF  out  1  marks the header word; qualified by OUT_VALID.
- OUT_EOF  out  1  marks the checksum word; qualified by OUT_VALID.
- FRAME_CNT  out  16  completed-frame count; wraps at 2^16.
- ERR_OVF  out  1  sticky overflow error.
- ERR_UNF  out  1  sticky underflow error.
- ERR_CLR  in  1  clears both sticky error flags.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
Reset:
- RESET=1 forces state IDLE and clears the skid buffer, read and word counters, checksum, in-flight read tracking, FRAME_CNT, ERR_OVF and ERR_UNF.
- During reset all outputs are 0.
- Reset mid-frame abandons the frame with no EOF; in-flight FIFO data returning after reset is discarded.

States:
- IDLE -> HDR when ENABLE=1 and FIFO_RDCNT >= FRAME_LEN. FIFO_RE is asserted in the same cycle as this transition (first prefetch).
- HDR: OUT_VALID=1, OUT_SOF=1, OUT_DATA = {HDR_TAG, FRAME_CNT[7:0]}. Moves to DATA on acceptance (OUT_VALID & OUT_READY).
- DATA: OUT_DATA = skid head, OUT_VALID = skid non-empty. Each accepted word is added to the checksum. Moves to CSUM after the FRAME_LEN-th word is accepted.
- CSUM: OUT_DATA = checksum, OUT_EOF=1, OUT_VALID=1. On acceptance, FRAME_CNT increments and the state returns to IDLE.

Read issue:
- FIFO_RE=1 when reads_issued < FRAME_LEN, FIFO_EMPTY=0, and (in_flight + skid_occupancy − pop_this_cycle) < RD_LAT+1.
- FIFO_RE is never asserted in IDLE except on the start cycle, and never in CSUM.
- Data captured into the skid RD_LAT cycles after each RE.
- Exactly FRAME_LEN reads are issued per frame.

Skid buffer:
- Depth RD_LAT+1, so credits never overrun it.

Throughput:
- With RD_LAT=1 and OUT_READY held 1: SOF at start+1, data words on the next FRAME_LEN consecutive cycles, EOF on the cycle after that. That is FRAME_LEN+2 consecutive valid cycles.
- At least one IDLE cycle separates frames.

Handshake:
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA, OUT_SOF and OUT_EOF hold stable.
- OUT_VALID never drops without acceptance.

Checksum:
- 16-bit sum of the data words only, modulo 2^16 (no header, no carry out).
- Cleared on entry to HDR.

ENABLE:
- Deassertion mid-frame is ignored; the current frame completes.

Errors:
- ERR_OVF / ERR_UNF are set one cycle after FIFO_OVERFLOW / FIFO_UNDERFLOW is high.
- ERR_CLR clears them. A set in the same cycle as a clear wins (flag ends at 1).

Decomposition:
- Package adcfifo_frame_pkg holds:
  - state enum (IDLE, HDR, DATA, CSUM);
  - DATA_W=16, CNT_W=7 constants;
  - header-word build function.
- Sub-module adcfifo_frame_skid: parameterised depth/width synchronous FIFO with push, pop, head, count, and synchronous reset.

Test Plan:
- Basic frame: FRAME_LEN=32, preload FIFO with 0..31, ENABLE=1, OUT_READY=1 -> 34 consecutive valid words: 16'hA500, 0..31, then 16'h01F0 with EOF; FRAME_CNT=1.
- Backpressure: toggle OUT_READY randomly with 50% duty -> identical word sequence, each word held stable while not ready, exactly 32 FIFO_RE pulses, never more than 2 reads outstanding or buffered.
- Threshold gating: FIFO_RDCNT=31, ENABLE=1 -> stays IDLE, FIFO_RE=0, BUSY=0; the 32nd write arrives -> HDR on the next cycle.
- Mid-frame reset: RESET=1 for 1 cycle after 10 data words -> all outputs 0, FRAME_CNT=0; the next frame starts with header 16'hA500 and a correct checksum.
- Errors: FIFO_OVERFLOW pulse -> ERR_OVF=1 the next cycle and held; ERR_CLR together with a FIFO_UNDERFLOW pulse -> ERR_OVF=0, ERR_UNF=1.
- Wrap and sequence: 256 frames of 0xFFFF samples -> header low byte wraps 0xFF->0x00; checksum 16'hFFE0 (32×0xFFFF mod 2^16); FRAME_CNT=256.

Source files
------------

// File: rtl/adcfifo_frame_pkg.sv
// Shared types and helpers for the ADC FIFO read-side frame sequencer.
package adcfifo_frame_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StCsum
  } state_e;

  // Header word: tag in the upper byte, low byte of the frame counter below it.
  function automatic logic [DATA_W-1:0] build_hdr(input logic [7:0] tag,
                                                   input logic [7:0] cnt_lo);
    return {tag, cnt_lo};
  endfunction

endpackage

// File: rtl/adcfifo_frame_skid.sv
// Small synchronous circular FIFO that absorbs FIFO read data returning after RE.
module adcfifo_frame_skid #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [OCC_W-1:0] o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count < OCC_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      r_count <= r_count + OCC_W'(w_do_push) - OCC_W'(w_do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/adcfifo_frame_ctrl.sv
// Read-side sequencer: drains one frame from the ADC FIFO and emits header, samples
// and checksum on a valid/ready stream; tracks sticky FIFO errors and frame count.
module adcfifo_frame_ctrl
  import adcfifo_frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [7:0]  HDR_TAG   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [CNT_W-1:0]  i_fifo_rdcnt,
  input  logic [DATA_W-1:0] i_fifo_q,
  input  logic              i_fifo_overflow,
  input  logic              i_fifo_underflow,
  output logic              o_fifo_re,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_sof,
  output logic              o_out_eof,
  output logic [15:0]       o_frame_cnt,
  output logic              o_err_ovf,
  output logic              o_err_unf,
  input  logic              i_err_clr,
  output logic              o_busy
);

  localparam int unsigned SKID_DEPTH = RD_LAT + 1;
  localparam int unsigned OCC_W      = $clog2(SKID_DEPTH + 1);
  localparam int unsigned CRD_W      = 4;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_reads;
  logic [CNT_W-1:0]  r_words;
  logic [RD_LAT-1:0] r_rd_pipe;
  logic [DATA_W-1:0] r_csum;
  logic [15:0]       r_frame_cnt;
  logic              r_err_ovf;
  logic              r_err_unf;

  logic              w_start;
  logic              w_can_read;
  logic              w_re;
  logic              w_pop;
  logic              w_out_valid;
  logic              w_out_sof;
  logic              w_out_eof;
  logic [DATA_W-1:0] w_out_data;
  logic [DATA_W-1:0] w_skid_head;
  logic [OCC_W-1:0]  w_skid_cnt;
  logic              w_skid_empty;
  logic [CRD_W-1:0]  w_in_flight;
  logic [CRD_W-1:0]  w_credit_used;

  adcfifo_frame_skid #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (DATA_W)
  ) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (r_rd_pipe[RD_LAT-1]),
    .i_data  (i_fifo_q),
    .i_pop   (w_pop),
    .o_head  (w_skid_head),
    .o_count (w_skid_cnt),
    .o_empty (w_skid_empty)
  );

  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_in_flight = w_in_flight + CRD_W'(r_rd_pipe[i]);
    end
  end

  assign w_start = i_enable && (i_fifo_rdcnt >= CNT_W'(FRAME_LEN));
  assign w_pop   = (r_state == StData) && !w_skid_empty && i_out_ready;

  // Words in flight plus buffered, net of this cycle's pop, must leave room in the skid.
  assign w_credit_used = w_in_flight + CRD_W'(w_skid_cnt) - CRD_W'(w_pop);
  assign w_can_read    = (r_reads < CNT_W'(FRAME_LEN)) && !i_fifo_empty &&
                         (w_credit_used < CRD_W'(RD_LAT + 1));

  always_comb begin
    w_state_nxt = r_state;
    w_re        = 1'b0;
    w_out_valid = 1'b0;
    w_out_sof   = 1'b0;
    w_out_eof   = 1'b0;
    w_out_data  = '0;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_nxt = StHdr;
          w_re        = w_can_read;
        end
      end
      StHdr: begin
        w_out_valid = 1'b1;
        w_out_sof   = 1'b1;
        w_out_data  = build_hdr(HDR_TAG, r_frame_cnt[7:0]);
        w_re        = w_can_read;
        if (i_out_ready) begin
          w_state_nxt = StData;
        end
      end
      StData: begin
        w_out_valid = !w_skid_empty;
        w_out_data  = w_skid_head;
        w_re        = w_can_read;
        if (w_pop && (r_words == CNT_W'(FRAME_LEN - 1))) begin
          w_state_nxt = StCsum;
        end
      end
      StCsum: begin
        w_out_valid = 1'b1;
        w_out_eof   = 1'b1;
        w_out_data  = r_csum;
        if (i_out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_rd_pipe   <= '0;
      r_reads     <= '0;
      r_words     <= '0;
      r_csum      <= '0;
      r_frame_cnt <= '0;
      r_err_ovf   <= 1'b0;
      r_err_unf   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(w_re);

      if (r_state == StIdle) begin
        r_reads <= CNT_W'(w_re);
      end else if (w_re) begin
        r_reads <= r_reads + 1'b1;
      end

      if (r_state != StData) begin
        r_words <= '0;
      end else if (w_pop) begin
        r_words <= r_words + 1'b1;
      end

      if ((r_state == StIdle) && w_start) begin
        r_csum <= '0;
      end else if (w_pop) begin
        r_csum <= r_csum + w_skid_head;
      end

      if ((r_state == StCsum) && i_out_ready) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      // A new error pulse outranks a clear in the same cycle.
      if (i_fifo_overflow) begin
        r_err_ovf <= 1'b1;
      end else if (i_err_clr) begin
        r_err_ovf <= 1'b0;
      end
      if (i_fifo_underflow) begin
        r_err_unf <= 1'b1;
      end else if (i_err_clr) begin
        r_err_unf <= 1'b0;
      end
    end
  end

  assign o_fifo_re   = w_re && !i_reset;
  assign o_out_valid = w_out_valid && !i_reset;
  assign o_out_sof   = w_out_sof && !i_reset;
  assign o_out_eof   = w_out_eof && !i_reset;
  assign o_out_data  = i_reset ? '0 : w_out_data;
  assign o_frame_cnt = i_reset ? '0 : r_frame_cnt;
  assign o_err_ovf   = r_err_ovf && !i_reset;
  assign o_err_unf   = r_err_unf && !i_reset;
  assign o_busy      = (r_state != StIdle) && !i_reset;

endmodule
